if_fetch_unit: RTL and testbench

Instruction-fetch stage; the producer side of the IF/ID pipeline register. It owns the PC and issues requests to instruction memory over a req/ready handshake. It presents PCPlus4_o, Instruction_o and FetchValid to the IF/ID register. It honours IFIDStall backpressure by buffering a returned instruction, and applies branch/jump redirects, including discarding an in-flight response.

---
 rtl/if_pkg.sv | 17 +
 rtl/if_fetch_unit_if.sv | 10 +
 rtl/if_hold_buffer.sv | 32 +++
 rtl/if_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request bus: req/addr held until ready, rdata valid with req && ready.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_hold_buffer.sv
// Skid register for one fetched {PCPlus4, instruction} pair while IF/ID is stalled.
// Clear wins over load; one-cycle load latency.
module if_hold_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_pcplus4,
  input  logic [31:0] i_instr,
  output logic        o_valid,
  output logic [31:0] o_pcplus4,
  output logic [31:0] o_instr
);

  logic [63:0] r_data;
  logic        r_valid;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_valid <= 1'b0;
      r_data  <= 64'h0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= {i_pcplus4, i_instr};
    end
  end

  assign o_valid   = r_valid;
  assign o_pcplus4 = r_data[63:32];
  assign o_instr   = r_data[31:0];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding IF/ID: owns the PC, buffers a response under IFIDStall, drains a response orphaned by a redirect.
// Optional IF_PERF_CNT_EN adds FetchCount/BubbleCount performance counters.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IFIDStall,
  input  logic              Redirect,
  input  logic [31:0]       RedirectPC,
  if_fetch_unit_if.master   mem,
  output logic [31:0]       PCPlus4_o,
  output logic [31:0]       Instruction_o,
  output logic              FetchValid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       FetchCount,
  output logic [31:0]       BubbleCount
`endif
);

  fetch_state_t r_state, w_next_state;
  logic [31:0]  r_pc, w_pc_next;
  logic [31:0]  r_drain_addr, w_drain_next;
  logic [31:0]  w_redirect_pc, w_pc_plus4;
  logic         w_buf_load, w_buf_clear, w_buf_valid;
  logic [31:0]  w_buf_pcplus4, w_buf_instr;

  assign w_redirect_pc = word_align(RedirectPC);
  assign w_pc_plus4    = r_pc + PC_STEP;

  if_hold_buffer u_hold_buffer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_buf_load),
    .i_clear   (w_buf_clear),
    .i_pcplus4 (w_pc_plus4),
    .i_instr   (mem.imem_rdata),
    .o_valid   (w_buf_valid),
    .o_pcplus4 (w_buf_pcplus4),
    .o_instr   (w_buf_instr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
    end else begin
      r_state      <= w_next_state;
      r_pc         <= w_pc_next;
      r_drain_addr <= w_drain_next;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_pc_next     = r_pc;
    w_drain_next  = r_drain_addr;
    w_buf_load    = 1'b0;
    w_buf_clear   = 1'b0;
    mem.imem_req  = 1'b0;
    mem.imem_addr = r_pc;
    FetchValid    = 1'b0;
    Instruction_o = NOP_INSTR;
    PCPlus4_o     = w_pc_plus4;

    case (r_state)
      FETCH: begin
        mem.imem_req = 1'b1;
        if (Redirect) begin
          w_pc_next = w_redirect_pc;
          // An unanswered request must still complete at its original address.
          if (!mem.imem_ready) begin
            w_drain_next = r_pc;
            w_next_state = DRAIN;
          end
        end else if (mem.imem_ready) begin
          FetchValid    = 1'b1;
          Instruction_o = mem.imem_rdata;
          if (IFIDStall) begin
            w_buf_load   = 1'b1;
            w_next_state = HOLD;
          end else begin
            w_pc_next = w_pc_plus4;
          end
        end
      end

      HOLD: begin
        if (Redirect) begin
          w_buf_clear  = 1'b1;
          w_pc_next    = w_redirect_pc;
          w_next_state = FETCH;
        end else begin
          FetchValid    = w_buf_valid;
          Instruction_o = w_buf_instr;
          PCPlus4_o     = w_buf_pcplus4;
          if (!IFIDStall) begin
            w_buf_clear  = 1'b1;
            w_pc_next    = w_buf_pcplus4;
            w_next_state = FETCH;
          end
        end
      end

      DRAIN: begin
        mem.imem_req  = 1'b1;
        mem.imem_addr = r_drain_addr;
        if (Redirect) begin
          w_pc_next = w_redirect_pc;
        end
        if (mem.imem_ready) begin
          w_next_state = FETCH;
        end
      end

      default: begin
        w_next_state = FETCH;
      end
    endcase

    // Reset abandons any outstanding request and flushes the presented slot.
    if (rst) begin
      mem.imem_req  = 1'b0;
      FetchValid    = 1'b0;
      Instruction_o = NOP_INSTR;
      PCPlus4_o     = w_pc_plus4;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_count, r_bubble_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count  <= 32'h0;
      r_bubble_count <= 32'h0;
    end else begin
      if (FetchValid && !IFIDStall) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (!FetchValid) begin
        r_bubble_count <= r_bubble_count + 32'd1;
      end
    end
  end

  assign FetchCount  = r_fetch_count;
  assign BubbleCount = r_bubble_count;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: scoreboard of expected consumed instructions plus per-cycle bus checks.
module tb_if_fetch_unit;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] rpc_drv = 32'h0;
  logic        ready_drv = 1'b0;
  logic [31:0] pcplus4, instr;
  logic        fvalid;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  exp_t        e;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  if_fetch_unit_if bus ();
  assign bus.imem_ready = ready_drv;
  assign bus.imem_rdata = memword(bus.imem_addr);

  if_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .IFIDStall     (stall),
    .Redirect      (redir),
    .RedirectPC    (rpc_drv),
    .mem           (bus),
    .PCPlus4_o     (pcplus4),
    .Instruction_o (instr),
    .FetchValid    (fvalid)
`ifdef IF_PERF_CNT_EN
    ,
    .FetchCount    (fetch_cnt),
    .BubbleCount   (bubble_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic rdy, input logic st, input logic rd,
                     input logic [31:0] rp);
    @(posedge clk);
    #1;
    rst = r; ready_drv = rdy; stall = st; redir = rd; rpc_drv = rp;
    @(negedge clk);
  endtask

  function automatic exp_t mk(input logic [31:0] addr);
    exp_t x;
    x.pc4   = addr + 32'd4;
    x.instr = memword(addr);
    return x;
  endfunction

  // Every instruction the stage hands over (valid and not stalled) must match the queue head.
  always @(negedge clk) begin
    if (!rst && fvalid && !stall) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_pc4", pcplus4, e.pc4);
        check("sb_instr", instr, e.instr);
      end
    end
  end

  initial begin
    // reset
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_vld", {31'd0, fvalid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc4", pcplus4, 32'd4);

    // zero-wait streaming
    for (int k = 0; k < 4; k++) begin
      sb.push_back(mk(32'(4 * k)));
      cyc(0, 1, 0, 0, 0);
      check("s1_addr", bus.imem_addr, 32'(4 * k));
      check("s1_vld", {31'd0, fvalid}, 32'd1);
    end

    // response at 0x10 under a 3-cycle stall
    sb.push_back(mk(32'h10));
    cyc(0, 1, 1, 0, 0);
    check("hold_addr", bus.imem_addr, 32'h10);
    check("hold_vld0", {31'd0, fvalid}, 32'd1);
    check("hold_pc40", pcplus4, 32'h14);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 1, 0, 0);
      check("hold_req", {31'd0, bus.imem_req}, 32'd0);
      check("hold_vld", {31'd0, fvalid}, 32'd1);
      check("hold_pc4", pcplus4, 32'h14);
      check("hold_instr", instr, memword(32'h10));
    end
    cyc(0, 0, 0, 0, 0);
    check("hold_rel_req", {31'd0, bus.imem_req}, 32'd0);

    // redirect coinciding with ready: data discarded
    cyc(0, 1, 0, 1, 32'h8);
    check("rdy_redir_addr", bus.imem_addr, 32'h14);
    check("rdy_redir_vld", {31'd0, fvalid}, 32'd0);
    check("rdy_redir_instr", instr, 32'h0);

    // memory wait states at 0x8
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 0, 0);
      check("wait_addr", bus.imem_addr, 32'h8);
      check("wait_req", {31'd0, bus.imem_req}, 32'd1);
      check("wait_vld", {31'd0, fvalid}, 32'd0);
    end
    sb.push_back(mk(32'h8));
    cyc(0, 1, 0, 0, 0);
    check("wait_done_vld", {31'd0, fvalid}, 32'd1);
    for (int a = 12; a < 32; a += 4) begin
      sb.push_back(mk(32'(a)));
      cyc(0, 1, 0, 0, 0);
      check("run_addr", bus.imem_addr, 32'(a));
    end

    // redirect while 0x20 waits, then a second redirect during drain
    cyc(0, 0, 0, 1, 32'h200);
    check("drain0_addr", bus.imem_addr, 32'h20);
    check("drain0_vld", {31'd0, fvalid}, 32'd0);
    cyc(0, 0, 0, 1, 32'h100);
    check("drain1_addr", bus.imem_addr, 32'h20);
    check("drain1_req", {31'd0, bus.imem_req}, 32'd1);
    cyc(0, 1, 0, 0, 0);
    check("drain2_addr", bus.imem_addr, 32'h20);
    check("drain2_vld", {31'd0, fvalid}, 32'd0);
    sb.push_back(mk(32'h100));
    cyc(0, 1, 0, 0, 0);
    check("post_drain_addr", bus.imem_addr, 32'h100);

    // redirect in HOLD while still stalled
    cyc(0, 1, 1, 0, 0);
    check("h2_addr", bus.imem_addr, 32'h104);
    check("h2_vld", {31'd0, fvalid}, 32'd1);
    cyc(0, 0, 1, 1, 32'h43);
    check("h2_redir_vld", {31'd0, fvalid}, 32'd0);
    check("h2_redir_req", {31'd0, bus.imem_req}, 32'd0);
    check("h2_redir_instr", instr, 32'h0);
    sb.push_back(mk(32'h40));
    cyc(0, 1, 0, 0, 0);
    check("h2_next_addr", bus.imem_addr, 32'h40);

    // PC wrap at the top of the address space
    cyc(0, 1, 0, 1, 32'hFFFF_FFFC);
    sb.push_back(mk(32'hFFFF_FFFC));
    cyc(0, 1, 0, 0, 0);
    check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    check("wrap_pc4", pcplus4, 32'h0);
    sb.push_back(mk(32'h0));
    cyc(0, 1, 0, 0, 0);
    check("wrap_next", bus.imem_addr, 32'h0);

    // reset while a request waits
    cyc(0, 0, 0, 0, 0);
    check("mid_addr", bus.imem_addr, 32'h4);
    cyc(1, 0, 0, 0, 0);
    check("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("mid_rst_vld", {31'd0, fvalid}, 32'd0);
    cyc(0, 0, 0, 0, 0);
    check("post_rst_req", {31'd0, bus.imem_req}, 32'd1);
    check("post_rst_addr", bus.imem_addr, 32'h0);
    sb.push_back(mk(32'h0));
    cyc(0, 1, 0, 0, 0);
    check("post_rst_vld", {31'd0, fvalid}, 32'd1);
    cyc(0, 0, 0, 0, 0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
